// File: rtl/mc_ctrl_hs.sv
// rtl/mc_ctrl_hs.sv - multicycle RV32I control unit with variable-latency memory handshake
// Optional MC_ILLEGAL_TRAP_EN: ILLEGAL becomes a terminal trap state with illegal_instr output.
module mc_ctrl_hs #(
  parameter int ALUCTL_W = 4,
  parameter int WAIT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opc,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  input  logic                zero,
  input  logic                lt,
  input  logic                ltu,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                adr_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                mem_write,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          result_src,
  output logic [2:0]          imm_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                instr_done,
  output logic                mem_timeout,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic                illegal_instr,
`endif
  output logic [4:0]          state
);

  typedef enum logic [4:0] {
    S_FETCH     = 5'd0,
    S_DECODE    = 5'd1,
    S_EXEC_R    = 5'd2,
    S_EXEC_I    = 5'd3,
    S_WB_ALU    = 5'd4,
    S_MEM_ADDR  = 5'd5,
    S_MEM_RD    = 5'd6,
    S_MEM_WR    = 5'd7,
    S_WB_MEM    = 5'd8,
    S_BRANCH    = 5'd9,
    S_LUI       = 5'd10,
    S_AUIPC     = 5'd11,
    S_JALR_ADDR = 5'd12,
    S_JUMP      = 5'd13,
    S_JUMP_WB   = 5'd14,
    S_ILLEGAL   = 5'd15
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              r_timeout;
  logic              w_mem_state;
  logic              w_expire;
  logic [3:0]        w_alu_op;
  logic [3:0]        w_alu;
  logic              w_op_ill;
  logic              w_taken;
  logic              w_br_ill;

  // Only FETCH/MEM_RD/MEM_WR talk to memory, so only they can stall or expire.
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_expire    = w_mem_state && !mem_ready && (r_wait == '1);

  always_comb begin
    w_op_ill = 1'b0;
    case (func3)
      3'b000:  w_alu_op = ((r_state == S_EXEC_R) && func7[5]) ? 4'd1 : 4'd0;
      3'b001:  w_alu_op = 4'd7;
      3'b010:  w_alu_op = 4'd5;
      3'b011:  w_alu_op = 4'd6;
      3'b100:  w_alu_op = 4'd4;
      3'b101:  w_alu_op = func7[5] ? 4'd9 : 4'd8;
      3'b110:  w_alu_op = 4'd3;
      default: w_alu_op = 4'd2;
    endcase
    if ((func7 != 7'b0000000) && (func7 != 7'b0100000))
      w_op_ill = (r_state == S_EXEC_R) || (func3 == 3'b001) || (func3 == 3'b101);
  end

  always_comb begin
    w_br_ill = 1'b0;
    case (func3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = !zero;
      3'b100:  w_taken = lt;
      3'b101:  w_taken = !lt;
      3'b110:  w_taken = ltu;
      3'b111:  w_taken = !ltu;
      default: begin
        w_taken  = 1'b0;
        w_br_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    instr_done = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    imm_src    = 3'b000;
    w_alu      = 4'd0;
    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opc == 7'b1101111) ? 3'b100 : 3'b010;
        case (opc)
          7'b0110011:             w_next = S_EXEC_R;
          7'b0010011:             w_next = S_EXEC_I;
          7'b0000011, 7'b0100011: w_next = S_MEM_ADDR;
          7'b1100011:             w_next = S_BRANCH;
          7'b0110111:             w_next = S_LUI;
          7'b0010111:             w_next = S_AUIPC;
          7'b1101111:             w_next = S_JUMP;
          7'b1100111:             w_next = S_JALR_ADDR;
          default:                w_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = (r_state == S_EXEC_I) ? 2'b01 : 2'b00;
        w_alu     = w_alu_op;
        w_next    = w_op_ill ? S_ILLEGAL : S_WB_ALU;
      end
      S_WB_ALU, S_JUMP_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = opc[5] ? 3'b001 : 3'b000;
        w_next    = opc[5] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) w_next = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = !w_expire;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        w_alu     = 4'd1;
        if (w_br_ill) begin
          w_next = S_ILLEGAL;
        end else begin
          pc_write   = w_taken;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_LUI: begin
        imm_src    = 3'b011;
        result_src = 2'b11;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b011;
        w_next    = S_WB_ALU;
      end
      S_JALR_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = S_JUMP;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        w_next    = S_JUMP_WB;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_ILLEGAL: w_next = S_ILLEGAL;
`else
      S_ILLEGAL: begin
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
`endif
      default: w_next = S_FETCH;
    endcase
    // An expired wait abandons the instruction; the retry starts again at FETCH.
    if (w_expire) w_next = S_FETCH;
    if (!rst) begin
      mem_req    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_expire) r_timeout <= 1'b1;
      if (w_expire || mem_ready || (w_next != r_state)) r_wait <= '0;
      else if (w_mem_state) r_wait <= r_wait + 1'b1;
    end
  end

  assign alu_control = ALUCTL_W'(w_alu);
  assign mem_timeout = r_timeout;
  assign state       = r_state;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_instr = (r_state == S_ILLEGAL);
`endif

endmodule

// File: doc/mc_ctrl_hs.md
# mc_ctrl_hs

Parametrised multicycle RV32I control unit with a variable-latency memory handshake. It sits between the instruction/data memory port and the shared-ALU multicycle datapath, and sequences fetch, decode, execute, memory and writeback one instruction at a time. Compared with the fixed-latency controller, it adds:
- wait states on `mem_ready` and a memory timeout;
- unsigned compares, shifts, AUIPC and all six branches;
- an optional illegal-instruction trap.

## Interface
- `ALUCTL_W`, 4: width of `alu_control`; must be ≥4, upper bits zero.
- `WAIT_W`, 4: width of the memory wait counter; timeout after 2^WAIT_W−1 stalled cycles.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-low. State → FETCH, counters and sticky flags → 0.
- `opc` in 7, `func3` in 3, `func7` in 7: fields of the instruction register.
- `zero`, `lt`, `ltu` in 1: ALU flags for the SUB result (equal, signed less-than, unsigned less-than).
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request active.
- `adr_src` out 1: 0 = PC, 1 = ALUOut.
- `ir_write`, `pc_write`, `reg_write`, `mem_write` out 1: write strobes.
- `alu_src_a` out 2: 00 PC, 01 oldPC, 10 rs1.
- `alu_src_b` out 2: 00 rs2, 01 imm, 10 constant 4.
- `result_src` out 2: 00 ALUOut, 01 memory data, 10 ALU result, 11 imm.
- `imm_src` out 3: 000 I, 001 S, 010 B, 011 U, 100 J.
- `alu_control` out ALUCTL_W: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `mem_timeout` out 1: sticky; set on a wait-counter expiry.
- `state` out 5: current state, for debug.

## Operation
- Outputs are combinational from state and inputs. All unlisted outputs are 0 in every state.
- While `rst` = 0, all strobes are forced to 0 and `mem_req` = 0. After reset release, state = FETCH.

States and actions:
- **FETCH:** `mem_req`=1, `adr_src`=0, ALU = PC+4 (`alu_src_a`=00, `alu_src_b`=10, ADD), `result_src`=10.
  - `ir_write` and `pc_write` are asserted only in the cycle where `mem_ready`=1; that cycle moves to DECODE.
- **DECODE:** ALU = oldPC+imm (ADD), latched into ALUOut. `imm_src`=100 (J) for JAL, otherwise 010 (B). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 / 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 0110111 → LUI
  - 0010111 → AUIPC
  - 1101111 → JUMP
  - 1100111 → JALR_ADDR
  - any other opcode → ILLEGAL
- **EXEC_R:** rs1 op rs2, → WB_ALU.
  - ADD/SUB are selected by `func7[5]`.
  - AND, OR, XOR, SLT, SLTU, SLL map by func3. SRL/SRA are selected by `func7[5]`.
  - A `func7` other than 0000000/0100000 → ILLEGAL.
- **EXEC_I:** rs1 op imm (I), same func3 map. Shifts use `func7` as in EXEC_R; other ops ignore `func7`. → WB_ALU.
- **WB_ALU:** `reg_write`=1, `result_src`=00, `instr_done`=1, → FETCH.
- **MEM_ADDR:** ALU = rs1+imm. `imm_src`=000 for loads, 001 for stores. → MEM_RD (load) or MEM_WR (store).
- **MEM_RD:** `mem_req`=1, `adr_src`=1. Holds until `mem_ready`, then → WB_MEM.
- **MEM_WR:** `mem_req`=1, `adr_src`=1, `mem_write`=1. Holds until `mem_ready`; on that cycle `instr_done`=1, → FETCH.
- **WB_MEM:** `reg_write`=1, `result_src`=01, `instr_done`=1, → FETCH.
- **BRANCH:** ALU = rs1−rs2 (SUB), `result_src`=00, `instr_done`=1, → FETCH. `pc_write` = taken condition by func3:
  - 000: `zero`
  - 001: !`zero`
  - 100: `lt`
  - 101: !`lt`
  - 110: `ltu`
  - 111: !`ltu`
  - func3 010/011 → ILLEGAL with no `pc_write`.
- **LUI:** `imm_src`=011, `result_src`=11, `reg_write`=1, `instr_done`=1, → FETCH.
- **AUIPC:** ALU = oldPC+imm (U), → WB_ALU.
- **JALR_ADDR:** ALU = rs1+imm (I), → JUMP.
- **JUMP:** `pc_write`=1, `result_src`=00, ALU = oldPC+4, → JUMP_WB.
- **JUMP_WB:** `reg_write`=1, `result_src`=00, `instr_done`=1, → FETCH.
- **ILLEGAL:** see Configuration.

## Timing
- Wait counter:
  - Increments on each cycle with `mem_req`=1 and `mem_ready`=0.
  - Clears on `mem_ready`=1 or on a state change.
  - At all-ones: `mem_timeout` is set, no strobe is asserted, and the controller goes to FETCH (instruction abandoned, retried from PC).
  - `mem_ready` arriving on the all-ones cycle counts as completion, not a timeout.
- Zero-wait-state memory gives these latencies:
  - R/I/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/LUI: 3 cycles.
  - JAL: 4 cycles.
  - JALR: 5 cycles.
- Each stalled cycle adds 1.
- `rst` asserted mid-instruction aborts it immediately. No strobe is asserted in the reset cycle.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - ILLEGAL is a terminal state with all strobes 0 and `mem_req`=0.
  - Output `illegal_instr` (1 bit) is high while in ILLEGAL.
  - Only `rst` leaves ILLEGAL.
- Undefined:
  - ILLEGAL asserts `instr_done`=1 for one cycle and → FETCH (NOP semantics).
  - `illegal_instr` is absent.

## Test plan
- `add` (opc 0110011, f3 000, f7 0000000), `mem_ready`=1 → states FETCH, DECODE, EXEC_R, WB_ALU. `alu_control`=0 in EXEC_R, `reg_write`=1 in cycle 4.
- `lw` with `mem_ready` low for 3 cycles in MEM_RD → MEM_RD held 4 cycles, then WB_MEM with `result_src`=01. 8 cycles total.
- `bltu` (f3 110) with `ltu`=1 → `pc_write`=1 in BRANCH. Same with `ltu`=0 → `pc_write`=0. Both 3 cycles.
- `WAIT_W`=2, `mem_ready` held 0 in FETCH → `mem_timeout`=1 after 3 stalled cycles, `ir_write` never asserted, state returns to FETCH.
- Opcode 1111111 → with macro: `illegal_instr`=1 and stuck until `rst`. Without macro: `instr_done` pulse, then FETCH.
- `rst` driven low during MEM_WR with `mem_ready`=1 → `mem_write`=0 immediately, state=FETCH after release.
